// File: rtl/huffman_bit_packer_if.sv
// huffman_bit_packer_if
//   Avalon-MM read-only slave bus between the host and the bit packer.
//   Signals:
//     chipselect  host -> packer  slave select
//     read        host -> packer  read strobe
//     address     host -> packer  register select (2 bits)
//     readdata    packer -> host  registered read data (32 bits)
//     word_ready  packer -> host  FIFO holds at least one word
//   Modports: master (host side), slave (packer side).
interface huffman_bit_packer_if;
  logic        chipselect;
  logic        read;
  logic [1:0]  address;
  logic [31:0] readdata;
  logic        word_ready;

  modport master (
    output chipselect, read, address,
    input  readdata, word_ready
  );

  modport slave (
    input  chipselect, read, address,
    output readdata, word_ready
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
//   Collects the serial Huffman bitstream MSB-first into 32-bit words and
//   queues them, with their valid-bit count, in a small FIFO that the host
//   drains over an Avalon-MM read port. A flush pulse closes a message by
//   pushing the partial word left-aligned and zero-padded.
//   Ports:
//     clock      sole clock, rising edge
//     reset      synchronous active-high reset
//     bit_in     coded bit
//     bit_valid  bit_in valid this cycle
//     flush      closes the current word
//     bus        huffman_bit_packer_if.slave (chipselect/read/address/
//                readdata/word_ready)
//   Register map: 0 DATA (pop), 1 STATUS, 2 BITCNT, 3 reads 0.
//   Optional feature macro: HUFFMAN_PACKER_BITCOUNT_EN enables the
//   saturating, clear-on-read 32-bit count of received bits at address 2.
module huffman_bit_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  flush,
  huffman_bit_packer_if.slave   bus
);

  localparam int PTR_W = LVL_W - 1;

  // Packer state: shreg holds bit_cnt bits right-aligned.
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;

  // FIFO storage and bookkeeping.
  logic [31:0]      mem_word [FIFO_DEPTH];
  logic [5:0]       mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic             ovf;

  logic [31:0] bits_now;
  logic [5:0]  pend_cnt;
  logic [5:0]  shamt;
  logic        word_full;
  logic        push_req;
  logic [31:0] push_word;
  logic        empty;
  logic        full;
  logic        rd_en;
  logic        pop;
  logic        push_ok;
  logic [31:0] status;
  logic [31:0] bitcnt_val;

  // Packer next-state view: the bits and count including this cycle's bit,
  // so a flush arriving together with a bit still includes that bit.
  always_comb begin
    bits_now  = bit_valid ? {shreg[30:0], bit_in} : shreg;
    pend_cnt  = bit_cnt + {5'd0, bit_valid};
    shamt     = 6'd32 - pend_cnt;
    word_full = bit_valid && (bit_cnt == 6'd31);
    push_req  = word_full || (flush && (pend_cnt != 6'd0));
    push_word = bits_now << shamt;
  end

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign rd_en = bus.chipselect && bus.read;
  assign pop   = rd_en && (bus.address == 2'd0) && !empty;
  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign push_ok = push_req && (!full || pop);

  assign bus.word_ready = !empty;

  // Packer shift register and bit counter; any push empties the packer.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (push_req) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_valid) begin
      shreg   <= bits_now;
      bit_cnt <= pend_cnt;
    end
  end

  // FIFO storage is not reset; the level counter alone says what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_word[wr_ptr] <= push_word;
      mem_cnt[wr_ptr]  <= pend_cnt;
    end
  end

  // Pointers and fill level; a dropped push sets the sticky overflow flag,
  // which a STATUS read clears unless a new overflow happens that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (pop && !push_ok) level <= level - 1'b1;
      if (push_req && !push_ok)                     ovf <= 1'b1;
      else if (rd_en && (bus.address == 2'd1))      ovf <= 1'b0;
    end
  end

`ifdef HUFFMAN_PACKER_BITCOUNT_EN
  logic [31:0] bitcnt_total;

  // Saturating received-bit counter; a read clears it but still counts a
  // bit arriving in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt_total <= '0;
    end else if (rd_en && (bus.address == 2'd2)) begin
      bitcnt_total <= {31'd0, bit_valid};
    end else if (bit_valid && (bitcnt_total != 32'hFFFF_FFFF)) begin
      bitcnt_total <= bitcnt_total + 32'd1;
    end
  end

  assign bitcnt_val = bitcnt_total;
`else
  assign bitcnt_val = 32'd0;
`endif

  // STATUS word assembled from live FIFO state.
  always_comb begin
    status              = '0;
    status[31]          = ovf;
    status[30]          = full;
    status[29]          = empty;
    status[21:16]       = empty ? 6'd0 : mem_cnt[rd_ptr];
    status[LVL_W-1:0]   = level;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      case (bus.address)
        2'd0:    bus.readdata <= empty ? 32'd0 : mem_word[rd_ptr];
        2'd1:    bus.readdata <= status;
        2'd2:    bus.readdata <= bitcnt_val;
        default: bus.readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer
//   Directed self-checking bench for huffman_bit_packer (FIFO_DEPTH 16).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point, after the edge has settled.
module tb_huffman_bit_packer;

  logic clock;
  logic reset;
  logic bit_in;
  logic bit_valid;
  logic flush;
  int   vectors;
  int   miscompares;

  huffman_bit_packer_if bus ();

  huffman_bit_packer #(.FIFO_DEPTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle with the given inputs applied.
  task automatic applyStimulus(input logic b, input logic v, input logic f,
                               input logic cs, input logic rd,
                               input logic [1:0] addr);
    bit_in         = b;
    bit_valid      = v;
    flush          = f;
    bus.chipselect = cs;
    bus.read       = rd;
    bus.address    = addr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readReg(input logic [1:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, addr);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Feeds 32 bits MSB-first; the last bit may carry a flush and/or a DATA read.
  task automatic feedWord(input logic [31:0] w, input logic last_flush,
                          input logic last_read);
    for (int i = 31; i >= 1; i--)
      applyStimulus(w[i], 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(w[0], 1'b1, last_flush, last_read, last_read, 2'd0);
  endtask

  initial begin
    logic [31:0] exp_bitcnt;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idleCycle();
    idleCycle();
    reset       = 1'b0;

    // Reset state.
    checkOutput("reset_word_ready", {31'd0, bus.word_ready}, 32'd0);
    checkOutput("reset_readdata", bus.readdata, 32'd0);
    readReg(2'd1);
    checkOutput("reset_status", bus.readdata, 32'h2000_0000);

    // Full 32-bit word.
    for (int i = 31; i >= 1; i--)
      applyStimulus(logic'((32'hA5A5_F00F >> i) & 1), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("ready_before_32nd", {31'd0, bus.word_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("ready_after_32nd", {31'd0, bus.word_ready}, 32'd1);
    readReg(2'd1);
    checkOutput("status_one_word", bus.readdata, 32'h0020_0001);
    readReg(2'd0);
    checkOutput("data_a5a5", bus.readdata, 32'hA5A5_F00F);
    readReg(2'd1);
    checkOutput("status_empty_again", bus.readdata, 32'h2000_0000);

    // Partial word 10110 then flush.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    readReg(2'd1);
    checkOutput("status_flush5", bus.readdata, 32'h0005_0001);
    readReg(2'd0);
    checkOutput("data_flush5", bus.readdata, 32'hB000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    readReg(2'd1);
    checkOutput("status_empty_flush", bus.readdata, 32'h2000_0000);

    // Flush arriving with a bit: 101 then flush+1 gives 1011, count 4.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    readReg(2'd1);
    checkOutput("status_flush4", bus.readdata, 32'h0004_0001);
    readReg(2'd0);
    checkOutput("data_flush4", bus.readdata, 32'hB000_0000);

    // Push and pop at empty: pop returns 0, push lands.
    feedWord(32'h1234_5678, 1'b0, 1'b1);
    checkOutput("data_empty_pop", bus.readdata, 32'd0);
    readReg(2'd1);
    checkOutput("status_empty_push", bus.readdata, 32'h0020_0001);
    readReg(2'd0);
    checkOutput("data_12345678", bus.readdata, 32'h1234_5678);

    // Fill the FIFO; word 0 ends with a flush on its 32nd bit.
    for (int k = 0; k < 16; k++)
      feedWord(32'hDEAD_0000 | k, (k == 0), 1'b0);
    readReg(2'd1);
    checkOutput("status_full", bus.readdata, 32'h4020_0010);
    feedWord(32'hBAD0_BAD0, 1'b0, 1'b0);
    readReg(2'd1);
    checkOutput("status_ovf", bus.readdata, 32'hC020_0010);
    readReg(2'd1);
    checkOutput("status_ovf_cleared", bus.readdata, 32'h4020_0010);

    // Push and pop at full.
    feedWord(32'h1357_9BDF, 1'b0, 1'b1);
    checkOutput("data_full_pop", bus.readdata, 32'hDEAD_0000);
    readReg(2'd1);
    checkOutput("status_full_pushpop", bus.readdata, 32'h4020_0010);
    for (int k = 1; k < 16; k++) begin
      readReg(2'd0);
      checkOutput($sformatf("drain_%0d", k), bus.readdata, 32'hDEAD_0000 | k);
    end
    readReg(2'd0);
    checkOutput("drain_last", bus.readdata, 32'h1357_9BDF);
    readReg(2'd1);
    checkOutput("status_drained", bus.readdata, 32'h2000_0000);
    readReg(2'd0);
    checkOutput("data_when_empty", bus.readdata, 32'd0);

    // Bit counter: 37 bits then two BITCNT reads.
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    for (int i = 0; i < 37; i++)
      applyStimulus(logic'(i & 1), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef HUFFMAN_PACKER_BITCOUNT_EN
    exp_bitcnt = 32'd37;
`else
    exp_bitcnt = 32'd0;
`endif
    readReg(2'd2);
    checkOutput("bitcnt_37", bus.readdata, exp_bitcnt);
    readReg(2'd2);
    checkOutput("bitcnt_cleared", bus.readdata, 32'd0);

    // Read without chipselect is ignored: no pop, readdata held.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    checkOutput("no_cs_held", bus.readdata, 32'd0);
    readReg(2'd1);
    checkOutput("no_cs_no_pop", bus.readdata, 32'h0020_0001);
    readReg(2'd3);
    checkOutput("addr3_zero", bus.readdata, 32'd0);

    // Reset mid-word discards the 5 pending bits.
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    readReg(2'd1);
    checkOutput("reset_midword", bus.readdata, 32'h2000_0000);
    checkOutput("reset_midword_ready", {31'd0, bus.word_ready}, 32'd0);

    idleCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
